logic_unit_pipe: RTL and testbench

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

---
 rtl/logic_unit_pkg.sv | 27 ++
 rtl/logic_op_core.sv | 28 ++
 rtl/logic_unit_pipe.sv | 102 ++++++++++
 tb/tb_logic_unit_pipe.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared opcode definitions and bit-count helper for the logic unit pipeline.
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  // Counts ones in a zero-extended operand of up to 64 bits.
  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      c = c + 7'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise operator: y = f(op, a, b) over the full operand width.
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op_e'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      OP_PASS: y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready logic unit with accumulator feedback and
// zero/parity/popcount flags registered alongside the result.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] popcnt
);

  logic             s1_valid_q, s2_valid_q;
  logic [WIDTH-1:0] s1_res_q, s2_res_q;
  logic             zero_q, parity_q;
  logic [CNT_W-1:0] popcnt_q;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s2_load, accept;
  logic [WIDTH-1:0] acc_eff, b_eff, core_y;
  logic [6:0]       pc_full;
  logic             zero_d, parity_d;
  logic [CNT_W-1:0] popcnt_d;

  assign s2_load  = !s2_valid_q || out_ready;
  assign in_ready = !rst && (!s1_valid_q || s2_load);
  assign accept   = in_valid && in_ready;

  // A clear arriving with an accumulate beat must make that beat see zero.
  assign acc_eff = acc_clr ? '0 : acc_q;
  assign b_eff   = acc_en ? acc_eff : b;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .a  (a),
    .b  (b_eff),
    .op (op),
    .y  (core_y)
  );

  always_comb begin
    acc_d = acc_eff;
    if (accept && acc_en) begin
      acc_d = core_y;
    end
  end

  assign pc_full  = popcount64(64'(s1_res_q));
  assign popcnt_d = CNT_W'(pc_full);
  assign parity_d = ^s1_res_q;
  assign zero_d   = (s1_res_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_res_q   <= '0;
      s2_res_q   <= '0;
      zero_q     <= 1'b1;
      parity_q   <= 1'b0;
      popcnt_q   <= '0;
      acc_q      <= '0;
    end else begin
      acc_q <= acc_d;
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_res_q <= core_y;
        end
      end
      // Output registers only change when the held beat is taken or absent.
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_res_q <= s1_res_q;
          zero_q   <= zero_d;
          parity_q <= parity_d;
          popcnt_q <= popcnt_d;
        end
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = s2_res_q;
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign popcnt    = popcnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed-vector bench for logic_unit_pipe (WIDTH=16) with hand-computed results.
module tb_logic_unit_pipe;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_en;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             parity;
  logic [CNT_W-1:0] popcnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .parity    (parity),
    .popcnt    (popcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+1. Presents one beat with out_ready=1 and
  // checks the two-cycle latency and the flag values of the emerging result.
  task automatic run_beat(input string tag, input logic [2:0] o, input logic [15:0] va,
                          input logic [15:0] vb, input logic en, input logic clr,
                          input logic [15:0] exp);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = o;
    a         = va;
    b         = vb;
    acc_en    = en;
    acc_clr   = clr;
    @(negedge clk);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_en   = 1'b0;
    acc_clr  = 1'b0;
    @(negedge clk);
    chk({tag, ".early"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".result"}, 64'(result), 64'(exp));
    chk({tag, ".zero"}, 64'(zero), 64'(exp == 16'h0000));
    chk({tag, ".parity"}, 64'(parity), 64'(^exp));
    chk({tag, ".popcnt"}, 64'(popcnt), 64'($countones(exp)));
    $display("[TB] beat %s op=%0d a=%h b=%h acc_en=%0b clr=%0b -> result=%h", tag, o, va, vb, en, clr, result);
    @(posedge clk);
    #1;
  endtask

  logic [15:0] vec_a   [8] = '{16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hFFFF, 16'hF0F0, 16'hF0F0, 16'h1234};
  logic [15:0] vec_b   [8] = '{16'h0FF0, 16'h0FF0, 16'h0FF0, 16'h0FF0, 16'hFFFF, 16'h0FF0, 16'hFFFF, 16'hFFFF};
  logic [2:0]  vec_op  [8] = '{3'd1, 3'd3, 3'd0, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [15:0] vec_exp [8] = '{16'hFFF0, 16'h000F, 16'h00F0, 16'hFF0F, 16'h0000, 16'h00FF, 16'h0F0F, 16'h1234};

  logic [15:0] bp_a [3] = '{16'h1111, 16'h2222, 16'h3333};

  initial begin
    int idx;
    int got_n;
    logic rd;
    logic [15:0] got_q [$];

    rst = 1'b1; in_valid = 1'b1; op = 3'd7; a = 16'hBEEF; b = 16'h0;
    acc_en = 1'b1; acc_clr = 1'b0; out_ready = 1'b1;

    // Reset: beats presented while rst=1 are refused and never appear.
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.result", 64'(result), 64'd0);
    chk("rst.zero", 64'(zero), 64'd1);
    chk("rst.parity", 64'(parity), 64'd0);
    chk("rst.popcnt", 64'(popcnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; acc_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst.discard", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end

    // Every opcode on plain operands.
    for (int i = 0; i < 8; i++) begin
      run_beat($sformatf("op%0d", i), vec_op[i], vec_a[i], vec_b[i], 1'b0, 1'b0, vec_exp[i]);
    end

    // Accumulator chain; OR with a=0 reads the accumulator back unchanged.
    in_valid = 1'b0; acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    run_beat("acc1", 3'd4, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 16'h0001);
    run_beat("acc2", 3'd4, 16'h0003, 16'hFFFF, 1'b1, 1'b0, 16'h0002);
    run_beat("acc3", 3'd4, 16'h0007, 16'hFFFF, 1'b1, 1'b0, 16'h0005);
    run_beat("accrd", 3'd1, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'h0005);

    // Clear coincident with an accumulate beat.
    run_beat("accld", 3'd7, 16'hFF00, 16'h0000, 1'b1, 1'b0, 16'hFF00);
    run_beat("clrbeat", 3'd1, 16'h00FF, 16'h0000, 1'b1, 1'b1, 16'h00FF);
    run_beat("clrrd", 3'd1, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h00FF);

    // NOT ignores the accumulator operand but still updates it; acc_en=0 leaves it.
    run_beat("notacc", 3'd6, 16'h00F0, 16'h0000, 1'b1, 1'b0, 16'hFF0F);
    run_beat("noacc", 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    run_beat("notrd", 3'd1, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFF0F);

    // Backpressure: three beats offered against a stalled output.
    idx = 0;
    out_ready = 1'b0; op = 3'd7; b = 16'h0; acc_en = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_valid = (idx < 3);
      a = bp_a[idx < 3 ? idx : 2];
      @(negedge clk);
      rd = in_ready;
      if (cyc >= 2) begin
        chk("bp.valid", 64'(out_valid), 64'd1);
        chk("bp.hold", 64'(result), 64'h1111);
        chk("bp.holdpc", 64'(popcnt), 64'd4);
      end
      @(posedge clk);
      if (in_valid && rd) idx++;
      #1;
    end
    chk("bp.accepts", 64'(idx), 64'd2);
    chk("bp.in_ready", 64'(rd), 64'd0);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_valid = (idx < 3);
      a = bp_a[idx < 3 ? idx : 2];
      @(negedge clk);
      rd = in_ready;
      if (out_valid) got_q.push_back(result);
      @(posedge clk);
      if (in_valid && rd) idx++;
      #1;
    end
    in_valid = 1'b0;
    got_n = got_q.size();
    chk("bp.count", 64'(got_n), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp.order%0d", i), 64'(i < got_n ? got_q[i] : 16'hXXXX), 64'(bp_a[i]));
      $display("[TB] drained beat %0d result=%h", i, i < got_n ? got_q[i] : 16'h0);
    end

    // Reset with two beats in flight under a stall.
    out_ready = 1'b0; op = 3'd7; acc_en = 1'b0;
    in_valid = 1'b1; a = 16'hAAAA;
    @(posedge clk);
    #1;
    a = 16'h5555;
    @(posedge clk);
    #1;
    rst = 1'b1; a = 16'h7777;
    @(negedge clk);
    chk("mid.in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("mid.result", 64'(result), 64'd0);
    chk("mid.zero", 64'(zero), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid.out_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    run_beat("midacc", 3'd1, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'h0000);
    run_beat("after", 3'd4, 16'hA5A5, 16'h0F0F, 1'b0, 1'b0, 16'hAAAA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
